// File: rtl/ram16x8.sv
// ram16x8 -- 16 x 8 single-port RAM with power-on clearing sweep and a
// separate program-load port.
//
// After clr is released the block spends 2**AW cycles writing zero to every
// location (INIT, busy=1). It then serves bus reads and writes (RUN), or
// accepts program writes over a valid/ready handshake while prog=1 (PROG).
//
// Ports
//   clk     in   sole clock, rising edge
//   clr     in   asynchronous active-high reset
//   addrin  in   run-mode address (from the memory address register)
//   busin   in   run-mode write data
//   we      in   run-mode write enable
//   re      in   run-mode read request
//   busout  out  registered read data, holds its last value between reads
//   bus_oe  out  one-cycle pulse marking busout valid after a read
//   prog    in   program-mode select
//   pvalid  in   program write offered
//   paddr   in   program write address
//   pdata   in   program write data
//   pready  out  high in every PROG cycle
//   busy    out  high while the clearing sweep runs
module ram16x8 #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] addrin,
  input  logic [DW-1:0] busin,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] busout,
  output logic          bus_oe,
  input  logic          prog,
  input  logic          pvalid,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pdata,
  output logic          pready,
  output logic          busy
);

  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_PROG
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [DW-1:0] busout_q, busout_d;
  logic          bus_oe_q, bus_oe_d;
  logic          busy_q, pready_q;

  logic [DW-1:0] mem [DEPTH];

  // Single write port shared by the sweep, the bus and the program port.
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    busout_d  = busout_q;
    bus_oe_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addrin;
    mem_wdata = busin;

    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        // Counter wraps back to zero exactly as the last location is cleared.
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == LAST) begin
          state_d = prog ? ST_PROG : ST_RUN;
        end
      end

      ST_RUN: begin
        mem_we = we;
        if (re) begin
          bus_oe_d = 1'b1;
          // Write-first: a same-cycle write is forwarded to the read data.
          busout_d = we ? busin : mem[addrin];
        end
        if (prog) begin
          state_d = ST_PROG;
        end
      end

      ST_PROG: begin
        // pready is high throughout PROG, so pvalid alone completes a handshake.
        if (pvalid) begin
          mem_we    = 1'b1;
          mem_waddr = paddr;
          mem_wdata = pdata;
        end
        if (!prog) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      busout_q <= '0;
      bus_oe_q <= 1'b0;
      busy_q   <= 1'b1;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      busout_q <= busout_d;
      bus_oe_q <= bus_oe_d;
      busy_q   <= (state_d == ST_INIT);
      pready_q <= (state_d == ST_PROG);
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it instead. Writes are
  // suppressed while clr is held so an aborted operation leaves no trace.
  always_ff @(posedge clk) begin
    if (mem_we && !clr) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busout = busout_q;
  assign bus_oe = bus_oe_q;
  assign busy   = busy_q;
  assign pready = pready_q;

endmodule

// File: tb/tb_ram16x8.sv
// tb_ram16x8 -- directed scenarios followed by randomized traffic, all
// outputs compared every cycle against a behavioural model of the RAM.
module tb_ram16x8;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] addrin, paddr;
  logic [7:0] busin, pdata;
  logic       we, re, prog, pvalid;
  logic [7:0] busout;
  logic       bus_oe, pready, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram16x8 #(.DW(8), .AW(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .addrin (addrin),
    .busin  (busin),
    .we     (we),
    .re     (re),
    .busout (busout),
    .bus_oe (bus_oe),
    .prog   (prog),
    .pvalid (pvalid),
    .paddr  (paddr),
    .pdata  (pdata),
    .pready (pready),
    .busy   (busy)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_mem [16];
  int         m_left;   // clearing cycles still to run; >0 means sweeping
  bit         m_prog;   // program mode once the sweep is done
  logic [7:0] e_out;
  bit         e_oe;

  function automatic void model_reset();
    m_left = 16;
    m_prog = 1'b0;
    e_out  = 8'h00;
    e_oe   = 1'b0;
  endfunction

  // One rising edge of the RAM as described behaviourally.
  function automatic void model_edge();
    if (clr) begin
      model_reset();
      return;
    end
    e_oe = 1'b0;
    if (m_left > 0) begin
      m_mem[16 - m_left] = 8'h00;
      m_left--;
      if (m_left == 0) m_prog = prog;
    end else if (!m_prog) begin
      if (we) m_mem[addrin] = busin;
      if (re) begin
        e_out = m_mem[addrin];
        e_oe  = 1'b1;
      end
      m_prog = prog;
    end else begin
      if (pvalid) m_mem[paddr] = pdata;
      m_prog = prog;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    check("busout", 32'(busout), 32'(e_out));
    check("bus_oe", 32'(bus_oe), 32'(e_oe));
    check("busy",   32'(busy),   32'(m_left > 0));
    check("pready", 32'(pready), 32'(m_left == 0 && m_prog));
  endtask

  // Advance one edge, update the model, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; pvalid = 1'b0;
  endtask

  // Assert clr between edges and verify the outputs react without a clock.
  task automatic async_reset();
    clr = 1'b1;
    #2;
    model_reset();
    check("rst_busout", 32'(busout), 32'h00);
    check("rst_bus_oe", 32'(bus_oe), 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_busy",   32'(busy),   32'h1);
  endtask

  initial begin
    int n;
    clr = 1'b1; prog = 1'b0; addrin = '0; paddr = '0; busin = '0; pdata = '0;
    idle();
    model_reset();
    repeat (2) tick();

    // Release reset: sweep lasts 16 cycles; reads and program writes offered
    // early in the sweep must be ignored.
    clr = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      re = (n < 8); pvalid = (n < 8); addrin = 4'd5; paddr = 4'd5; pdata = 8'hAA;
      tick();
      n++;
    end
    idle();
    check("busy_len", 32'(n), 32'd16);

    // Cleared location reads back zero with a single bus_oe pulse.
    re = 1'b1; addrin = 4'd7;
    tick();
    check("rd7_data", 32'(busout), 32'h00);
    check("rd7_oe", 32'(bus_oe), 32'h1);
    idle(); tick();

    // Plain write then read.
    we = 1'b1; addrin = 4'd3; busin = 8'hA5; tick();
    we = 1'b0; re = 1'b1; tick();
    check("rd3_data", 32'(busout), 32'hA5);
    idle(); tick();
    check("rd3_oe_once", 32'(bus_oe), 32'h0);

    // Write-first forwarding, then a later read of the same word.
    we = 1'b1; re = 1'b1; addrin = 4'd9; busin = 8'h3C; tick();
    check("wf9_data", 32'(busout), 32'h3C);
    idle(); tick();
    re = 1'b1; tick();
    check("rd9_data", 32'(busout), 32'h3C);
    idle();

    // Program mode: handshake writes, bus writes ignored.
    prog = 1'b1; tick();
    check("prog_ready", 32'(pready), 32'h1);
    pvalid = 1'b1; paddr = 4'd15; pdata = 8'hFF;
    we = 1'b1; addrin = 4'd2; busin = 8'h55; tick();
    idle(); prog = 1'b0; tick();
    re = 1'b1; addrin = 4'd15; tick();
    check("rd15_data", 32'(busout), 32'hFF);
    addrin = 4'd2; tick();
    check("rd2_data", 32'(busout), 32'h00);
    idle(); tick();

    // Reset mid-handshake aborts it; sweep clears the programmed word.
    prog = 1'b1; tick();
    pvalid = 1'b1; paddr = 4'd15; pdata = 8'hFF; tick();
    async_reset();
    repeat (2) tick();
    clr = 1'b0; prog = 1'b0; idle();
    repeat (16) tick();
    re = 1'b1; addrin = 4'd15; tick();
    check("rd15_after_clr", 32'(busout), 32'h00);
    idle(); tick();

    // Randomized traffic with occasional mode changes and resets.
    for (int i = 0; i < 3000; i++) begin
      we     = 1'($urandom_range(0, 1));
      re     = 1'($urandom_range(0, 1));
      pvalid = 1'($urandom_range(0, 1));
      addrin = 4'($urandom_range(0, 15));
      paddr  = 4'($urandom_range(0, 15));
      busin  = 8'($urandom);
      pdata  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) prog = ~prog;
      clr    = ($urandom_range(0, 299) == 0);
      tick();
    end
    clr = 1'b0;

    // Drain to RUN and read back every word.
    prog = 1'b0; idle();
    repeat (20) tick();
    for (int a = 0; a < 16; a++) begin
      re = 1'b1; addrin = 4'(a);
      tick();
    end
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram16x8.md
RAM16X8 -- requirements
Module: ram16x8

Interface
REQ-001 Parameter DW, default 8, data word width.
REQ-002 Parameter AW, default 4, address width; depth is 2**AW (16 words).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 addrin  input  AW  run-mode address, driven by the memory address register output.
REQ-006 busin  input  DW  run-mode write data from the bus.
REQ-007 we  input  1  run-mode write enable.
REQ-008 re  input  1  run-mode read request.
REQ-009 busout  output  DW  registered read data.
REQ-010 bus_oe  output  1  busout valid / bus drive enable, one-cycle pulse per read.
REQ-011 prog  input  1  program-mode select.
REQ-012 pvalid  input  1  program write offered.
REQ-013 paddr  input  AW  program write address.
REQ-014 pdata  input  DW  program write data.
REQ-015 pready  output  1  block accepts program writes.
REQ-016 busy  output  1  initialisation sweep in progress.

Function
REQ-017 Block SHALL implement states INIT, RUN, PROG.
REQ-018 INIT: each cycle SHALL write 0 to mem[sweep_cnt] and increment sweep_cnt; after writing location 2**AW-1 (16 cycles), next state SHALL be PROG if prog=1, else RUN.
REQ-019 INIT: we, re, pvalid SHALL be ignored; busy=1, bus_oe=0, pready=0.
REQ-020 RUN, we=1: mem[addrin] SHALL take busin at the edge.
REQ-021 RUN, re=1: busout SHALL take mem[addrin] at the edge and bus_oe SHALL be 1 for exactly the following cycle (latency 1).
REQ-022 RUN, we=1 and re=1 same cycle: write-first; busout SHALL take busin.
REQ-023 bus_oe SHALL be 0 in any cycle not following an accepted read; busout SHALL hold its last value.
REQ-024 RUN, prog=1: next state SHALL be PROG; we/re in that cycle SHALL still be serviced.
REQ-025 PROG: pready SHALL be 1 in every PROG cycle, 0 in all other states.
REQ-026 PROG, pvalid=1 and pready=1: mem[paddr] SHALL take pdata at the edge.
REQ-027 PROG: we and re SHALL be ignored; bus_oe=0.
REQ-028 PROG, prog=0: next state SHALL be RUN; a handshake in that same cycle SHALL complete.
REQ-029 busy SHALL be 1 only in INIT.
REQ-030 Addresses are AW bits; every address is valid, no out-of-range condition; sweep_cnt wraps only on exit from INIT.

Reset
REQ-031 clr=1 SHALL immediately (no clock edge) force state=INIT, sweep_cnt=0, busout=0, bus_oe=0, pready=0, busy=1.
REQ-032 Reset asserted in any state, including mid-sweep or mid-handshake, SHALL abort the operation; the sweep SHALL restart on the first edge after clr deasserts and clear all 16 locations.
REQ-033 Memory contents SHALL be all-zero on leaving INIT.

Verification
REQ-034 Release clr, prog=0 -> busy=1 for 16 cycles then 0; re at addrin=7 -> busout=0x00, bus_oe=1 one cycle.
REQ-035 RUN: we, addrin=3, busin=0xA5; then re, addrin=3 -> next cycle busout=0xA5, bus_oe=1 for one cycle only.
REQ-036 RUN: we=1, re=1, addrin=9, busin=0x3C -> busout=0x3C next cycle; later re at 9 -> 0x3C.
REQ-037 prog=1 -> pready=1; pvalid, paddr=15, pdata=0xFF; we=1, addrin=2, busin=0x55 same window ignored; prog=0, re at 15 -> 0xFF, re at 2 -> 0x00.
REQ-038 During INIT re=1, pvalid=1 -> bus_oe=0, pready=0, no memory change.
REQ-039 After writing 0xFF at 15, assert clr mid-PROG -> busout=0, bus_oe=0, pready=0, busy=1 without clock edge; after sweep re at 15 -> 0x00.
